mux_scan_sequencer: RTL and testbench
=====================================

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 Parameter DWELL, default 2: number of clock cycles sel is held on each channel before y is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 mask  input  4  channel enable, bit k enables channel k; latched on accepted start.
REQ-006 y  input  1  output of the downstream 4x1 mux for the current sel.
REQ-007 sel  output  2  channel select driven to the 4x1 mux.
REQ-008 busy  output  1  high while a scan is in progress.
REQ-009 done  output  1  one-cycle pulse marking scan completion.
REQ-010 data  output  4  scan result, bit k = sampled y of channel k (0 for masked channels).

Function
REQ-011 The FSM SHALL have states IDLE, SCAN and DONE; reset enters IDLE.
REQ-012 In IDLE, start=1 SHALL be accepted: mask latched, shadow result cleared, and the FSM moves to SCAN if mask!=0, otherwise to DONE.
REQ-013 On entry to SCAN, sel SHALL equal the lowest-numbered enabled channel, and the dwell counter SHALL load DWELL-1.
REQ-014 In SCAN, sel SHALL be held constant for exactly DWELL cycles; y SHALL be captured into shadow bit sel at the rising edge ending the last dwell cycle.
REQ-015 After a capture, sel SHALL advance to the next higher enabled channel (channel order 0..3, no wrap), reloading the counter; after the highest enabled channel, the FSM moves to DONE.
REQ-016 With N enabled channels (N>=1), done SHALL be high during the cycle that begins at the N*DWELL-th rising edge after the edge that accepted start; with mask=0, at the 1st edge.
REQ-017 In DONE, done=1 and busy=0 for exactly one cycle; data SHALL update atomically from the shadow register at the edge entering DONE and hold until the next DONE.
REQ-018 busy SHALL be 1 in SCAN only; it rises at the edge accepting start (N>=1).
REQ-019 start asserted in SCAN or DONE SHALL be ignored; mask changes during a scan SHALL have no effect.
REQ-020 DONE SHALL return to IDLE unconditionally; start in the IDLE cycle following DONE is accepted normally.
REQ-021 In IDLE, sel SHALL hold its last value; masked channels SHALL never be selected during a scan.

Reset
REQ-022 rst=1 at a rising edge SHALL force IDLE, sel=0, busy=0, done=0, data=0, shadow=0, counter=0, latched mask=0, regardless of state.
REQ-023 Reset asserted mid-scan SHALL abort the scan with no done pulse, and data SHALL read 0.
REQ-024 rst SHALL take priority over start in the same cycle.

Configuration
REQ-025 Macro MUX_SCAN_CONT_EN SHALL select continuous mode.
REQ-026 With MUX_SCAN_CONT_EN defined, DONE SHALL go directly to SCAN (or DONE again if mask=0) using a freshly latched mask, without start; the done pulse repeats per scan, and busy re-rises the cycle after done.
REQ-027 Continuous mode SHALL only start after the first accepted start following reset.
REQ-028 Without MUX_SCAN_CONT_EN, behaviour SHALL be single-shot per REQ-020.

Verification
REQ-029 DWELL=2, mask=1111, mux I=1010 -> sel 0,0,1,1,2,2,3,3; done at the 8th edge after start; data=1010.
REQ-030 DWELL=1, mask=0101, I=1111 -> sel 0 then 2; done at the 2nd edge; data=0101; sel never 1 or 3.
REQ-031 mask=0000, start -> done at the 1st edge, busy stays 0, data=0000.
REQ-032 DWELL=2, mask=1111, start held high throughout, mask changed to 0001 mid-scan -> single scan of all 4 channels, one done pulse, no restart while busy.
REQ-033 rst pulsed at the 3rd edge of a mask=1111 scan -> no done; all outputs 0; the next start runs a full scan correctly.
REQ-034 MUX_SCAN_CONT_EN, DWELL=1, mask=0011, one start pulse -> done every 3 cycles indefinitely; I change 01->10 is reflected in the next data.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// mux_scan_sequencer
//
// Walks the select lines of a downstream 4x1 mux across the enabled channels,
// dwells DWELL cycles on each one, samples the mux output at the end of the
// dwell and publishes the collected bits as a 4-bit result with a done pulse.
//
// Parameters
//    DWELL   cycles sel is held per channel before y is sampled (1..15)
//
// Ports
//    clk     single rising-edge clock
//    rst     synchronous, active-high reset
//    start   scan request, only looked at while idle
//    mask    channel enables (bit k = channel k), latched when a scan starts
//    y       output of the downstream mux for the current sel
//    sel     channel select driven to the mux
//    busy    high while channels are being scanned
//    done    one-cycle pulse when a scan result is published
//    data    scan result, bit k = sampled y of channel k (0 if masked)
//
// Configuration
//    MUX_SCAN_CONT_EN  when defined, the sequencer rescans continuously after
//                      the first accepted start, re-latching mask every scan.
// ---------------------------------------------------------------------------
module mux_scan_sequencer #(
   parameter int DWELL = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] mask,
   input  logic       y,
   output logic [1:0] sel,
   output logic       busy,
   output logic       done,
   output logic [3:0] data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } stateT;

   localparam logic [3:0] DWELL_LOAD = 4'(DWELL - 1);

   stateT      state, stateNext;
   logic [1:0] selNext;
   logic [3:0] dwellCnt, dwellCntNext;
   logic [3:0] maskLatched, maskLatchedNext;
   logic [3:0] shadow, shadowNext;
   logic [3:0] dataNext;
   logic [3:0] captured;
   logic [2:0] firstHit;
   logic [2:0] nextHit;
   logic       launch;

   // Returns {found, index} of the lowest enabled channel at or above lo.
   // lo may be 4, meaning "past the last channel", which never finds anything.
   function automatic logic [2:0] findFrom(input logic [3:0] m, input logic [2:0] lo);
      logic [2:0] res;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         if (m[k] && (k >= int'(lo))) begin
            res = {1'b1, 2'(k)};
         end
      end
      return res;
   endfunction

   // State and datapath registers; reset clears everything so an aborted scan
   // leaves no trace in the published result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sel         <= 2'd0;
         dwellCnt    <= 4'd0;
         maskLatched <= 4'd0;
         shadow      <= 4'd0;
         data        <= 4'd0;
      end else begin
         state       <= stateNext;
         sel         <= selNext;
         dwellCnt    <= dwellCntNext;
         maskLatched <= maskLatchedNext;
         shadow      <= shadowNext;
         data        <= dataNext;
      end
   end

   // Next-state logic. A "launch" (accepted start, or a rescan in continuous
   // mode) latches a fresh mask and jumps straight to the first enabled
   // channel. In SCAN the dwell counter counts down; when it reaches zero the
   // current y is captured and sel moves on, or the scan finishes. The value
   // published to data is the shadow including the final capture, so data
   // changes in one step on the edge entering DONE.
   always_comb begin
      stateNext       = state;
      selNext         = sel;
      dwellCntNext    = dwellCnt;
      maskLatchedNext = maskLatched;
      shadowNext      = shadow;
      dataNext        = data;
      captured        = shadow;
      launch          = 1'b0;
      firstHit        = findFrom(mask, 3'd0);
      nextHit         = findFrom(maskLatched, {1'b0, sel} + 3'd1);

      case (state)
         IDLE: begin
            launch = start;
         end
         SCAN: begin
            if (dwellCnt == 4'd0) begin
               captured[sel] = y;
               shadowNext    = captured;
               if (nextHit[2]) begin
                  selNext      = nextHit[1:0];
                  dwellCntNext = DWELL_LOAD;
               end else begin
                  stateNext = DONE;
                  dataNext  = captured;
               end
            end else begin
               dwellCntNext = dwellCnt - 4'd1;
            end
         end
         DONE: begin
`ifdef MUX_SCAN_CONT_EN
            launch = 1'b1;
`else
            stateNext = IDLE;
`endif
         end
         default: begin
            stateNext = IDLE;
         end
      endcase

      if (launch) begin
         maskLatchedNext = mask;
         shadowNext      = 4'd0;
         if (firstHit[2]) begin
            stateNext    = SCAN;
            selNext      = firstHit[1:0];
            dwellCntNext = DWELL_LOAD;
         end else begin
            stateNext = DONE;
            dataNext  = 4'd0;
         end
      end
   end

   assign busy = (state == SCAN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_sequencer
//
// Directed bench for mux_scan_sequencer. Two instances share clk/rst:
//    dutA  DWELL=2, used for the full four-channel scans
//    dutB  DWELL=1, used for sparse masks, the empty mask and continuous mode
// Each instance sees a modelled 4x1 mux: y = in[sel].
// Outputs are sampled 1 ns after the rising edge; inputs change there too.
// ---------------------------------------------------------------------------
module tb_mux_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst;

   logic       startA, startB;
   logic [3:0] maskA, maskB;
   logic [3:0] inA, inB;
   logic       yA, yB;
   logic [1:0] selA, selB;
   logic       busyA, busyB;
   logic       doneA, doneB;
   logic [3:0] dataA, dataB;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Downstream 4x1 muxes
   assign yA = inA[selA];
   assign yB = inB[selB];

   mux_scan_sequencer #(.DWELL(2)) dutA (
      .clk(clk), .rst(rst), .start(startA), .mask(maskA), .y(yA),
      .sel(selA), .busy(busyA), .done(doneA), .data(dataA)
   );

   mux_scan_sequencer #(.DWELL(1)) dutB (
      .clk(clk), .rst(rst), .start(startB), .mask(maskB), .y(yB),
      .sel(selB), .busy(busyB), .done(doneB), .data(dataB)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset must clear all outputs of both instances
   task automatic test_reset();
      rst = 1'b1;
      startA = 1'b0; startB = 1'b0;
      maskA = 4'd0;  maskB = 4'd0;
      inA = 4'd0;    inB = 4'd0;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (selA !== 2'd0 || busyA !== 1'b0 || doneA !== 1'b0 || dataA !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset_A: sel=%0d busy=%b done=%b data=%b, want 0/0/0/0000", selA, busyA, doneA, dataA);
      end
      checks++;
      if (selB !== 2'd0 || busyB !== 1'b0 || doneB !== 1'b0 || dataB !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset_B: sel=%0d busy=%b done=%b data=%b, want 0/0/0/0000", selB, busyB, doneB, dataB);
      end
   endtask

   // DWELL=2, all channels, mux inputs 1010: sel 0,0,1,1,2,2,3,3 then done
   task automatic test_full_scan();
      maskA = 4'b1111;
      inA   = 4'b1010;
      startA = 1'b1;
      tick();
      startA = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (selA !== 2'(i / 2) || busyA !== 1'b1 || doneA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_scan cycle %0d: sel=%0d busy=%b done=%b, want sel=%0d busy=1 done=0", i, selA, busyA, doneA, i / 2);
         end
         tick();
      end
      checks++;
      if (doneA !== 1'b1 || busyA !== 1'b0 || dataA !== 4'b1010) begin
         errors++;
         $display("[TB] FAIL full_scan_done: done=%b busy=%b data=%b, want done=1 busy=0 data=1010", doneA, busyA, dataA);
      end
      tick();
      checks++;
      if (doneA !== 1'b0 || busyA !== 1'b0 || dataA !== 4'b1010) begin
         errors++;
         $display("[TB] FAIL full_scan_after: done=%b busy=%b data=%b, want done=0 busy=0 data=1010", doneA, busyA, dataA);
      end
   endtask

   // DWELL=1, mask 0101: only channels 0 and 2 are visited, done at 2nd edge
   task automatic test_sparse_mask();
      maskB = 4'b0101;
      inB   = 4'b1111;
      startB = 1'b1;
      tick();
      startB = 1'b0;
      checks++;
      if (selB !== 2'd0 || busyB !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sparse_first: sel=%0d busy=%b, want sel=0 busy=1", selB, busyB);
      end
      tick();
      checks++;
      if (selB !== 2'd2 || busyB !== 1'b1 || doneB !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sparse_second: sel=%0d busy=%b done=%b, want sel=2 busy=1 done=0", selB, busyB, doneB);
      end
      tick();
      checks++;
      if (doneB !== 1'b1 || busyB !== 1'b0 || dataB !== 4'b0101) begin
         errors++;
         $display("[TB] FAIL sparse_done: done=%b busy=%b data=%b, want done=1 busy=0 data=0101", doneB, busyB, dataB);
      end
      tick();
   endtask

   // Empty mask goes straight to DONE at the accepting edge with data 0000
   task automatic test_empty_mask();
      maskB = 4'b0000;
      inB   = 4'b1111;
      startB = 1'b1;
      tick();
      startB = 1'b0;
      checks++;
      if (doneB !== 1'b1 || busyB !== 1'b0 || dataB !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL empty_done: done=%b busy=%b data=%b, want done=1 busy=0 data=0000", doneB, busyB, dataB);
      end
      tick();
      checks++;
      if (doneB !== 1'b0 || busyB !== 1'b0) begin
         errors++;
         $display("[TB] FAIL empty_after: done=%b busy=%b, want done=0 busy=0", doneB, busyB);
      end
   endtask

   // start held high and mask changed mid-scan: one full scan, one done pulse
   task automatic test_start_held();
      int doneCount;
      doneCount = 0;
      maskA = 4'b1111;
      inA   = 4'b0110;
      startA = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         if (i == 3) maskA = 4'b0001;
         if (doneA === 1'b1) doneCount++;
         checks++;
         if (busyA !== 1'b1 || selA !== 2'(i / 2)) begin
            errors++;
            $display("[TB] FAIL held_scan cycle %0d: busy=%b sel=%0d, want busy=1 sel=%0d", i, busyA, selA, i / 2);
         end
         tick();
      end
      checks++;
      if (doneA !== 1'b1 || dataA !== 4'b0110) begin
         errors++;
         $display("[TB] FAIL held_done: done=%b data=%b, want done=1 data=0110", doneA, dataA);
      end
      tick();
      startA = 1'b0;
      checks++;
      if (doneA !== 1'b0 || busyA !== 1'b0 || doneCount !== 0) begin
         errors++;
         $display("[TB] FAIL held_after: done=%b busy=%b early_dones=%0d, want 0/0/0", doneA, busyA, doneCount);
      end
      tick();
   endtask

   // Reset at the 3rd edge aborts the scan; rst beats start; next scan is clean
   task automatic test_reset_mid_scan();
      maskA = 4'b1111;
      inA   = 4'b1010;
      startA = 1'b1;
      tick();
      startA = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (selA !== 2'd0 || busyA !== 1'b0 || doneA !== 1'b0 || dataA !== 4'd0) begin
         errors++;
         $display("[TB] FAIL abort_state: sel=%0d busy=%b done=%b data=%b, want 0/0/0/0000", selA, busyA, doneA, dataA);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (doneA !== 1'b0 || busyA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_quiet cycle %0d: done=%b busy=%b, want 0/0", i, doneA, busyA);
         end
         tick();
      end
      rst = 1'b1;
      startA = 1'b1;
      tick();
      rst = 1'b0;
      startA = 1'b0;
      checks++;
      if (busyA !== 1'b0 || doneA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_priority: busy=%b done=%b, want 0/0", busyA, doneA);
      end
      inA = 4'b1001;
      startA = 1'b1;
      tick();
      startA = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (doneA !== 1'b1 || dataA !== 4'b1001) begin
         errors++;
         $display("[TB] FAIL rescan_done: done=%b data=%b, want done=1 data=1001", doneA, dataA);
      end
      tick();
   endtask

   // Continuous mode, DWELL=1, mask 0011: done every 3 cycles, data tracks inputs
   task automatic test_continuous();
      maskB = 4'b0011;
      inB   = 4'b0001;
      startB = 1'b1;
      tick();
      startB = 1'b0;
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (doneB !== (k % 3 == 2) || busyB !== (k % 3 != 2)) begin
            errors++;
            $display("[TB] FAIL cont_pulse edge %0d: done=%b busy=%b, want done=%b busy=%b", k, doneB, busyB, (k % 3 == 2), (k % 3 != 2));
         end
         if (k == 2) begin
            checks++;
            if (dataB !== 4'b0001) begin
               errors++;
               $display("[TB] FAIL cont_data_first: data=%b, want 0001", dataB);
            end
            inB = 4'b0010;
         end else if (k % 3 == 2) begin
            checks++;
            if (dataB !== 4'b0010) begin
               errors++;
               $display("[TB] FAIL cont_data edge %0d: data=%b, want 0010", k, dataB);
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
`ifdef MUX_SCAN_CONT_EN
      test_continuous();
`else
      test_full_scan();
      test_sparse_mask();
      test_empty_mask();
      test_start_held();
      test_reset_mid_scan();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
